// File: rtl/jk_input_debounce.sv
// ============================================================================
// jk_input_debounce
// ----------------------------------------------------------------------------
// Input-conditioning stage for the JK flip-flop lab board. Raw slide-switch
// and push-button levels are brought into the CLK domain through a two-flop
// synchroniser. Each channel is then debounced against a shared slow sample
// tick. The stage delivers clean registered levels plus one-cycle rise and
// fall pulses that are aligned with the level change.
//
// Parameters
//   N             number of independent input channels
//   TICK_DIV      CLK cycles per debounce sample tick (>= 2)
//   STABLE_TICKS  consecutive ticks a changed level must persist (>= 1)
//   INIT          reset value of synchroniser stages and Dout
//                 (set bits to 1 for active-low lines such as Setn/Clrn)
//
// Ports
//   CLK   in   1  system clock, the only clock in the block
//   RST   in   1  synchronous active-high reset
//   Din   in   N  raw asynchronous switch/button levels
//   Dout  out  N  debounced levels, registered
//   Rise  out  N  one-cycle pulse in the first cycle Dout[i] reads 1 after 0
//   Fall  out  N  one-cycle pulse in the first cycle Dout[i] reads 0 after 1
//   Tick  out  1  sample strobe, high one cycle every TICK_DIV cycles
// ============================================================================
module jk_input_debounce #(
    parameter int unsigned  N            = 10,
    parameter int unsigned  TICK_DIV     = 50_000,
    parameter int unsigned  STABLE_TICKS = 20,
    parameter logic [N-1:0] INIT         = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] Din,
    output logic [N-1:0] Dout,
    output logic [N-1:0] Rise,
    output logic [N-1:0] Fall,
    output logic         Tick
);

    // ------------------------------------------------------------------------
    // Widths and terminal values. The tick counter only ever holds
    // 0..TICK_DIV-1, so clog2(TICK_DIV) bits are enough. The stability
    // counter never exceeds STABLE_TICKS-1, and clog2(STABLE_TICKS+1) bits
    // keep it at least one bit wide when STABLE_TICKS is 1.
    // ------------------------------------------------------------------------
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    // ------------------------------------------------------------------------
    // Shared sample-tick generator
    // ------------------------------------------------------------------------
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;

    // The strobe is decoded combinationally from the counter. It therefore
    // sits high during the cycle that ends with the wrapping edge.
    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign Tick   = w_tick;

    // NOTE: every clocked block uses non-blocking assignments only. All flops
    // then sample pre-edge values, and simulation matches the synthesised
    // register behaviour.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Two-flop synchroniser. Only r_sync2 is allowed to feed decisions.
    // r_sync1 may go metastable on an asynchronous switch edge.
    // ------------------------------------------------------------------------
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= INIT;
            r_sync2 <= INIT;
        end else begin
            r_sync1 <= Din;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel debounce. Each channel owns its stability counter, its
    // level register and its edge-pulse registers. No state is shared
    // between channels, so any number of them may update on the same edge.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < int'(N); i++) begin : g_chan

        logic [CW-1:0] r_cnt;
        logic          r_dout;
        logic          r_rise;
        logic          r_fall;

        // NOTE: the stability counters are reset together with the level.
        // A reset in the middle of a count must discard the partial count.
        // Otherwise the first level change after reset could be accepted
        // early.
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_cnt  <= '0;
                r_dout <= INIT[i];
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                // Pulses last exactly one cycle unless re-armed below.
                r_rise <= 1'b0;
                r_fall <= 1'b0;

                if (r_sync2[i] == r_dout) begin
                    // The input agrees with the accepted level. This check
                    // runs on every cycle, not only on ticks, so a bounce
                    // back to the old level restarts the count at once.
                    r_cnt <= '0;
                end else if (w_tick && (r_cnt == CNT_LAST)) begin
                    // The new level has survived STABLE_TICKS sample ticks.
                    // Accept it, and flag the direction in the same cycle so
                    // the pulse lines up with the first cycle of the new
                    // level.
                    r_dout <= r_sync2[i];
                    r_cnt  <= '0;
                    r_rise <= r_sync2[i];
                    r_fall <= ~r_sync2[i];
                end else if (w_tick) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign Dout[i] = r_dout;
        assign Rise[i] = r_rise;
        assign Fall[i] = r_fall;

        // A channel can move in only one direction per update.
        a_rise_fall_excl: assert property (@(posedge CLK) !(r_rise && r_fall));

    end : g_chan

endmodule : jk_input_debounce

// File: tb/tb_jk_input_debounce.sv
// ============================================================================
// tb_jk_input_debounce
// ----------------------------------------------------------------------------
// Scoreboard bench for jk_input_debounce with N=4, TICK_DIV=4,
// STABLE_TICKS=3, INIT=4'b1000. Each stimulus call derives, from a small
// model of the accepted levels, which bits must rise and fall. It pushes
// that expectation together with the edge at which Din is first sampled.
// A monitor pops one entry per observed pulse and checks:
//   - the pulse bits;
//   - the new Dout;
//   - the latency window.
// Any pulse that arrives with nothing queued counts as a failure.
// ============================================================================
module tb_jk_input_debounce;

    localparam int          N        = 4;
    localparam int          TD       = 4;
    localparam int          ST       = 3;
    localparam logic [3:0]  INIT     = 4'b1000;
    localparam int          LAT_MIN  = 3 + (ST - 1) * TD;   // 11
    localparam int          LAT_MAX  = 2 + ST * TD;         // 14

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [3:0]   Din = 4'b0101;
    logic [3:0]   Dout;
    logic [3:0]   Rise;
    logic [3:0]   Fall;
    logic         Tick;

    jk_input_debounce #(
        .N            (N),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .INIT         (INIT)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .Din  (Din),
        .Dout (Dout),
        .Rise (Rise),
        .Fall (Fall),
        .Tick (Tick)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] dout;
        int         sample_edge;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         mon_lat;
    int         n_checks = 0;
    int         n_errors = 0;
    int         edge_no  = 0;
    logic [3:0] model_dout = INIT;

    always @(posedge CLK) edge_no++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called right after a falling edge: the next rising edge samples d.
    task automatic drive(input logic [3:0] d);
        exp_t e;
        Din    = d;
        e.rise = d & ~model_dout;
        e.fall = ~d & model_dout;
        e.dout = d;
        e.sample_edge = edge_no + 1;
        if ((e.rise | e.fall) != 4'b0000) sb_q.push_back(e);
        model_dout = d;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge CLK);
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if ((Rise | Fall) != 4'b0000) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {24'd0, Rise, Fall}, 32'd0);
            end else begin
                mon_e   = sb_q.pop_front();
                mon_lat = edge_no - mon_e.sample_edge + 1;
                check("pulse_rise", 32'(Rise), 32'(mon_e.rise));
                check("pulse_fall", 32'(Fall), 32'(mon_e.fall));
                check("pulse_dout", 32'(Dout), 32'(mon_e.dout));
                check($sformatf("latency_%0d_in_window", mon_lat),
                      32'(mon_lat >= LAT_MIN && mon_lat <= LAT_MAX), 32'd1);
            end
            check("rise_fall_excl", 32'(Rise & Fall), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Reset with Din=0101, then release; Tick cadence from release.
        RST = 1'b1;
        Din = 4'b0101;
        repeat (3) begin
            @(negedge CLK);
            check("rst_dout", 32'(Dout), 32'(INIT));
            check("rst_pulse", 32'({Rise, Fall}), 32'd0);
            check("rst_tick", 32'(Tick), 32'd0);
        end
        RST = 1'b0;
        drive(4'b0101);                     // bits 0,2 rise and bit 3 falls after debounce
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("tick_before_edge_%0d", k), 32'(Tick), 32'((k % TD) == 0));
            check($sformatf("dout_hold_%0d", k), 32'(Dout), 32'(INIT));
            @(negedge CLK);
        end
        wait_drain(40);

        // Return to INIT so the following tests start from the plan's levels.
        drive(4'b1000);
        wait_drain(40);

        // 2. Clean rise on channel 0.
        drive(4'b1001);
        wait_drain(40);
        check("clean_rise_dout", 32'(Dout), 32'h9);

        // 3. Bounce on channel 1: 1,0,1,0 for 5 cycles each, then 0.
        for (int p = 0; p < 4; p++) begin
            Din = model_dout | ((p % 2 == 0) ? 4'b0010 : 4'b0000);
            repeat (5) @(negedge CLK);
        end
        Din = model_dout;
        repeat (20) @(negedge CLK);
        check("bounce_dout", 32'(Dout), 32'h9);

        // 4. Channel 3 falls and channel 2 rises on the same sampling edge.
        drive(4'b0101);
        wait_drain(40);
        check("concurrent_dout", 32'(Dout), 32'h5);

        // 5. Reset in the middle of a count on channel 0.
        drive(4'b0100);
        wait_drain(40);
        Din = 4'b0101;                      // rise that reset must discard; not queued
        repeat (9) @(negedge CLK);
        check("mid_count_dout", 32'(Dout), 32'h4);
        RST = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            check("mid_rst_dout", 32'(Dout), 32'(INIT));
            check("mid_rst_pulse", 32'({Rise, Fall}), 32'd0);
        end
        RST = 1'b0;
        model_dout = INIT;
        drive(4'b0101);                     // full latency measured from release
        wait_drain(40);

        // 6. Long hold at 0110.
        drive(4'b0110);
        wait_drain(40);
        for (int c = 0; c < 10; c++) begin
            repeat (20) @(negedge CLK);
            check("hold_dout", 32'(Dout), 32'h6);
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_jk_input_debounce
